mvb_change_detect: RTL and testbench
====================================

# mvb_change_detect

Sparse-update encoder for the multi-value bus (MVB). It takes a dense MVB stream of per-item values and forwards only the items whose value differs from the nearest preceding valid item, tracking that item across word boundaries. The result is the sparse "update" stream that a last-valid aggregator at the far end expands back into the dense stream. It sits on the transmit side of such a link, in front of any serialisation or FIFO stage.

## Interface
- ITEMS, 4, number of items per MVB word (≥1)
- ITEM_WIDTH, 8, bits per item
- IMPLEMENTATION, "serial", previous-valid search structure: "serial" (ripple chain) or "prefix" (log-depth tree); both give identical results
- CLK  in  1  clock, all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- RX_DATA  in  ITEMS*ITEM_WIDTH  input items, item i at bits [(i+1)*ITEM_WIDTH-1 : i*ITEM_WIDTH]
- RX_VLD  in  ITEMS  per-item valid
- RX_SRC_RDY  in  1  input word present
- RX_DST_RDY  out  1  block can accept input word
- RX_RESYNC  in  1  sampled with an accepted word: discard history before this word
- TX_DATA  out  ITEMS*ITEM_WIDTH  output items, same positions as input
- TX_VLD  out  ITEMS  per-item valid (item is a change)
- TX_SRC_RDY  out  1  output word present
- TX_DST_RDY  in  1  downstream accepts output word

## Operation
- Input word accepted when RX_SRC_RDY=1 and RX_DST_RDY=1.
- History: register HIST_DATA (ITEM_WIDTH) plus flag HIST_VLD.
- Each valid input item i has a reference: the nearest valid item j<i in the same word. If none exists, the reference is HIST_DATA, which is used only when HIST_VLD=1.
- Item i is emitted (TX_VLD[i]=1) when RX_VLD[i]=1 and one of these holds: no reference exists, or the reference value differs from RX_DATA item i.
- Invalid input items never emit. Their data is ignored and they do not break the chain.
- TX_DATA item positions carry RX_DATA unchanged. Data at non-emitted positions is don't-care, but it equals the RX data.
- On an accepted word with any RX_VLD bit set, HIST_DATA is loaded with the highest-index valid item and HIST_VLD is set to 1.
- On an accepted word with no valid item, history is unchanged.
- RX_RESYNC=1 on an accepted word: the HIST reference is treated as absent for that word, so its first valid item always emits. History is then updated normally.
- Words whose emit mask is all-zero are consumed and not forwarded. TX_SRC_RDY is never asserted with TX_VLD=0.
- Comparison is exact bitwise equality over the full ITEM_WIDTH.

## Timing
- Reset values:
  - TX_SRC_RDY=0, TX_VLD=0, TX_DATA=0
  - HIST_VLD=0, HIST_DATA=0
  - RX_DST_RDY=1 while RESET_N=1 and the output register is empty
- Latency: 1 cycle. A word accepted at edge n appears on TX at edge n (registered outputs), valid in the following cycle.
- Output is a single register stage. RX_DST_RDY = TX_DST_RDY or not TX_SRC_RDY (combinational).
- Full throughput: one word per cycle while TX_DST_RDY=1.
- Stall: while TX_SRC_RDY=1 and TX_DST_RDY=0, TX_* hold stable and no input is accepted. History changes only on accepted input.
- Simultaneous TX handshake and new input: the output register is replaced in the same edge; no bubble.
- An input word with an empty emit mask, accepted while the output is transferring, clears TX_SRC_RDY at that edge.
- Reset asserted mid-operation clears the output register and history immediately (asynchronously). A word in flight is lost. The first valid item after reset emits.

## Structure
- Shared package mvb_change_detect_pkg holds:
  - the item/word slice helper functions
  - the IMPLEMENTATION string constants "serial" and "prefix"
- Sub-module mvb_prev_vld:
  - combinational, parameterised by ITEMS, ITEM_WIDTH, IMPLEMENTATION
  - inputs: word data, valid mask, and the incoming history value and valid flag
  - outputs per item: reference data and a reference-exists flag, plus the outgoing history value and valid flag
- The top level holds the comparators, the history register and the output register/handshake.

## Test plan
All scenarios use ITEMS=4, ITEM_WIDTH=8.
- After reset, word data 05,05,07,07 with VLD 1111 → TX_VLD 0101 (items 0 and 2), TX data 05,05,07,07; HIST=07.
- Next word data 07,09,xx,09 with VLD 1011 → TX_VLD 0010 (item 1=09); the gap does not break the chain; item 3 is 09=09 and suppressed; HIST=09.
- Word with VLD 0000, then word data 09 at item 0 only → neither is forwarded; TX_SRC_RDY stays 0; HIST stays 09.
- RX_RESYNC=1 with word data 09,09,09,09 and VLD 1111 → TX_VLD 0001.
- Hold TX_DST_RDY=0 for 5 cycles with a word pending → RX_DST_RDY=0 and TX stable. On release, words are delivered in order with no loss or duplication.
- Pull RESET_N low between two words → TX_SRC_RDY=0 at once; after release, data AA at item 0 with VLD 0001 emits TX_VLD 0001.
- Random 10000-word run with random stalls, for both IMPLEMENTATION values → TX output expanded by a last-valid model equals the RX valid items.

Source files
------------

// File: rtl/mvb_change_detect_pkg.sv
// Shared definitions for the MVB change-detect encoder: search-structure
// selectors and item slicing helpers.
package mvb_change_detect_pkg;

    localparam string IMPL_SERIAL = "serial";
    localparam string IMPL_PREFIX = "prefix";

    // Bit offset of item idx inside a packed MVB word.
    function automatic int item_lsb(input int idx, input int width);
        return idx * width;
    endfunction

    // Depth of a log-step scan over n elements.
    function automatic int scan_levels(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mvb_if.sv
// Multi-value bus word channel: packed items, per-item valid and a word handshake.
interface mvb_if #(
    parameter int ITEMS      = 4,
    parameter int ITEM_WIDTH = 8
) ();

    logic [ITEMS*ITEM_WIDTH-1:0] data;
    logic [ITEMS-1:0]            vld;
    logic                        src_rdy;
    logic                        dst_rdy;

    modport master (output data, vld, src_rdy, input dst_rdy);
    modport slave  (input data, vld, src_rdy, output dst_rdy);

endinterface

// File: rtl/mvb_prev_vld.sv
// Finds, for every item, the nearest preceding valid item (history counts as item -1),
// and the resulting last-valid value that leaves the word.
module mvb_prev_vld
    import mvb_change_detect_pkg::*;
#(
    parameter int    ITEMS          = 4,
    parameter int    ITEM_WIDTH     = 8,
    parameter string IMPLEMENTATION = IMPL_SERIAL
) (
    input  logic [ITEMS*ITEM_WIDTH-1:0] data,
    input  logic [ITEMS-1:0]            vld,
    input  logic [ITEM_WIDTH-1:0]       hist_data,
    input  logic                        hist_vld,
    output logic [ITEMS*ITEM_WIDTH-1:0] ref_data,
    output logic [ITEMS-1:0]            ref_vld,
    output logic [ITEM_WIDTH-1:0]       next_hist_data,
    output logic                        next_hist_vld
);

    localparam int N = ITEMS + 1;

    logic [ITEM_WIDTH-1:0] elem_d [N];
    logic                  elem_v [N];
    logic [ITEM_WIDTH-1:0] scan_d [N];
    logic                  scan_v [N];

    assign elem_d[0] = hist_data;
    assign elem_v[0] = hist_vld;

    for (genvar k = 0; k < ITEMS; k++) begin : g_elem
        assign elem_d[k+1] = data[item_lsb(k, ITEM_WIDTH) +: ITEM_WIDTH];
        assign elem_v[k+1] = vld[k];
    end

    // Inclusive "last valid wins" scan; scan[i] is the reference of item i.
    if (IMPLEMENTATION == IMPL_PREFIX) begin : g_prefix
        localparam int LEVELS = scan_levels(N);

        logic [ITEM_WIDTH-1:0] lvl_d [LEVELS+1][N];
        logic                  lvl_v [LEVELS+1][N];

        for (genvar m = 0; m < N; m++) begin : g_in
            assign lvl_d[0][m] = elem_d[m];
            assign lvl_v[0][m] = elem_v[m];
            assign scan_d[m]   = lvl_d[LEVELS][m];
            assign scan_v[m]   = lvl_v[LEVELS][m];
        end

        for (genvar lv = 0; lv < LEVELS; lv++) begin : g_lvl
            for (genvar m = 0; m < N; m++) begin : g_node
                if (m >= (1 << lv)) begin : g_comb
                    assign lvl_v[lv+1][m] = lvl_v[lv][m] | lvl_v[lv][m-(1<<lv)];
                    assign lvl_d[lv+1][m] = lvl_v[lv][m] ? lvl_d[lv][m]
                                                         : lvl_d[lv][m-(1<<lv)];
                end else begin : g_pass
                    assign lvl_v[lv+1][m] = lvl_v[lv][m];
                    assign lvl_d[lv+1][m] = lvl_d[lv][m];
                end
            end
        end
    end else begin : g_serial
        logic [ITEM_WIDTH-1:0] cur_d;
        logic                  cur_v;

        always_comb begin
            cur_d = elem_d[0];
            cur_v = 1'b0;
            for (int m = 0; m < N; m++) begin
                if (elem_v[m]) begin
                    cur_d = elem_d[m];
                    cur_v = 1'b1;
                end
                scan_d[m] = cur_d;
                scan_v[m] = cur_v;
            end
        end
    end

    for (genvar i = 0; i < ITEMS; i++) begin : g_out
        assign ref_data[item_lsb(i, ITEM_WIDTH) +: ITEM_WIDTH] = scan_d[i];
        assign ref_vld[i] = scan_v[i];
    end

    assign next_hist_data = scan_d[ITEMS];
    assign next_hist_vld  = scan_v[ITEMS];

endmodule

// File: rtl/mvb_change_detect.sv
// Sparse-update encoder: forwards only MVB items whose value differs from the
// nearest preceding valid item, tracked across words through a history register.
module mvb_change_detect
    import mvb_change_detect_pkg::*;
#(
    parameter int    ITEMS          = 4,
    parameter int    ITEM_WIDTH     = 8,
    parameter string IMPLEMENTATION = IMPL_SERIAL
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  rx_resync,
    mvb_if.slave  rx,
    mvb_if.master tx
);

    logic [ITEMS*ITEM_WIDTH-1:0] ref_data;
    logic [ITEMS-1:0]            ref_vld;
    logic [ITEM_WIDTH-1:0]       next_hist_data;
    logic                        next_hist_vld;
    logic [ITEM_WIDTH-1:0]       hist_data;
    logic                        hist_vld;
    logic [ITEMS-1:0]            emit;
    logic                        accept;

    logic [ITEMS*ITEM_WIDTH-1:0] data_p1;
    logic [ITEMS-1:0]            mask_p1;
    logic                        vld_p1;

    // Resync hides the history from this word only; it is still updated afterwards.
    mvb_prev_vld #(
        .ITEMS          (ITEMS),
        .ITEM_WIDTH     (ITEM_WIDTH),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_prev_vld (
        .data           (rx.data),
        .vld            (rx.vld),
        .hist_data      (hist_data),
        .hist_vld       (hist_vld & ~rx_resync),
        .ref_data       (ref_data),
        .ref_vld        (ref_vld),
        .next_hist_data (next_hist_data),
        .next_hist_vld  (next_hist_vld)
    );

    for (genvar i = 0; i < ITEMS; i++) begin : g_cmp
        assign emit[i] = rx.vld[i] &
                         (~ref_vld[i] |
                          (ref_data[item_lsb(i, ITEM_WIDTH) +: ITEM_WIDTH] !=
                           rx.data[item_lsb(i, ITEM_WIDTH) +: ITEM_WIDTH]));
    end

    assign rx.dst_rdy = tx.dst_rdy | ~vld_p1;
    assign accept     = rx.src_rdy & rx.dst_rdy;

    // p0 -> p1: output register and history update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_p1   <= '0;
            mask_p1   <= '0;
            vld_p1    <= 1'b0;
            hist_data <= '0;
            hist_vld  <= 1'b0;
        end else if (accept) begin
            data_p1 <= rx.data;
            mask_p1 <= emit;
            vld_p1  <= |emit;
            if (|rx.vld) begin
                hist_data <= next_hist_data;
                hist_vld  <= next_hist_vld;
            end
        end else if (tx.dst_rdy) begin
            vld_p1 <= 1'b0;
        end
    end

    assign tx.data    = data_p1;
    assign tx.vld     = mask_p1;
    assign tx.src_rdy = vld_p1;

endmodule

// File: tb/tb_mvb_change_detect.sv
// Bench for mvb_change_detect: serial and prefix instances driven in lockstep
// against a last-valid reference model, plus directed vectors and corner sequences.
module tb_mvb_change_detect;
    import mvb_change_detect_pkg::*;

    localparam int ITEMS = 4;
    localparam int W     = 8;
    localparam int DW    = ITEMS * W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          rx_resync;
    logic [DW-1:0] drv_data;
    logic [3:0]    drv_vld;
    logic          drv_src;
    logic          tx_rdy;

    mvb_if #(.ITEMS(ITEMS), .ITEM_WIDTH(W)) rx_s ();
    mvb_if #(.ITEMS(ITEMS), .ITEM_WIDTH(W)) tx_s ();
    mvb_if #(.ITEMS(ITEMS), .ITEM_WIDTH(W)) rx_p ();
    mvb_if #(.ITEMS(ITEMS), .ITEM_WIDTH(W)) tx_p ();

    assign rx_s.data = drv_data;  assign rx_p.data = drv_data;
    assign rx_s.vld = drv_vld;    assign rx_p.vld = drv_vld;
    assign rx_s.src_rdy = drv_src; assign rx_p.src_rdy = drv_src;
    assign tx_s.dst_rdy = tx_rdy;  assign tx_p.dst_rdy = tx_rdy;

    mvb_change_detect #(.ITEMS(ITEMS), .ITEM_WIDTH(W), .IMPLEMENTATION(IMPL_SERIAL)) u_ser (
        .clk(clk), .reset_n(reset_n), .rx_resync(rx_resync), .rx(rx_s), .tx(tx_s));

    mvb_change_detect #(.ITEMS(ITEMS), .ITEM_WIDTH(W), .IMPLEMENTATION(IMPL_PREFIX)) u_pre (
        .clk(clk), .reset_n(reset_n), .rx_resync(rx_resync), .rx(rx_p), .tx(tx_p));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: last valid value seen, and the word waiting at the output.
    logic [W-1:0]  m_hist;
    logic          m_hist_vld;
    logic          m_occ;
    logic [DW-1:0] m_data;
    logic [3:0]    m_mask;

    typedef struct {
        logic [DW-1:0] data;
        logic [3:0]    vld;
        logic          resync;
        logic          fwd;
        logic [3:0]    exp_vld;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_hist = '0; m_hist_vld = 1'b0;
        m_occ = 1'b0; m_data = '0; m_mask = '0;
    endtask

    function automatic logic [3:0] model_emit(input logic [DW-1:0] d, input logic [3:0] v,
                                              input logic rs);
        logic          have;
        logic [W-1:0]  prev;
        logic [W-1:0]  x;
        logic [3:0]    e;
        have = m_hist_vld && !rs;
        prev = m_hist;
        e    = '0;
        for (int i = 0; i < ITEMS; i++) begin
            if (v[i]) begin
                x = d[i*W +: W];
                if (!have || prev != x) e[i] = 1'b1;
                prev = x;
                have = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic check_dut(input string nm, input logic src, input logic dst,
                             input logic [3:0] vld, input logic [DW-1:0] data);
        chk({nm, ".src_rdy"}, src, m_occ);
        chk({nm, ".dst_rdy"}, dst, tx_rdy | !m_occ);
        if (m_occ) begin
            chk({nm, ".vld"}, vld, m_mask);
            chk({nm, ".data"}, data, m_data);
        end
    endtask

    task automatic check_both();
        check_dut("ser", tx_s.src_rdy, rx_s.dst_rdy, tx_s.vld, tx_s.data);
        check_dut("pre", tx_p.src_rdy, rx_p.dst_rdy, tx_p.vld, tx_p.data);
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare.
    task automatic step();
        logic [3:0] e;
        logic       acc;
        @(posedge clk);
        if (reset_n) begin
            acc = drv_src && (tx_rdy || !m_occ);
            if (acc) begin
                e = model_emit(drv_data, drv_vld, rx_resync);
                for (int i = 0; i < ITEMS; i++) begin
                    if (drv_vld[i]) begin
                        m_hist     = drv_data[i*W +: W];
                        m_hist_vld = 1'b1;
                    end
                end
                m_occ  = |e;
                m_data = drv_data;
                m_mask = e;
            end else if (tx_rdy) begin
                m_occ = 1'b0;
            end
        end
        #1;
        check_both();
    endtask

    task automatic drive(input logic [DW-1:0] d, input logic [3:0] v, input logic rs);
        drv_data = d; drv_vld = v; rx_resync = rs; drv_src = 1'b1;
    endtask

    initial begin
        vecs[0] = '{32'h07070505, 4'b1111, 1'b0, 1'b1, 4'b0101};
        vecs[1] = '{32'h09550907, 4'b1011, 1'b0, 1'b1, 4'b0010};
        vecs[2] = '{32'h12345678, 4'b0000, 1'b0, 1'b0, 4'b0000};
        vecs[3] = '{32'hEEEEEE09, 4'b0001, 1'b0, 1'b0, 4'b0000};
        vecs[4] = '{32'h09090909, 4'b1111, 1'b1, 1'b1, 4'b0001};
        vecs[5] = '{32'h0000000A, 4'b0001, 1'b0, 1'b1, 4'b0001};
        vecs[6] = '{32'h0A000000, 4'b1000, 1'b0, 1'b0, 4'b0000};

        reset_n = 1'b0; rx_resync = 1'b0; drv_data = '0; drv_vld = '0;
        drv_src = 1'b0; tx_rdy = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ser.src_rdy", tx_s.src_rdy, 1'b0);
        chk("reset.ser.vld", tx_s.vld, 4'b0000);
        chk("reset.ser.data", tx_s.data, 32'h0);
        chk("reset.ser.dst_rdy", rx_s.dst_rdy, 1'b1);
        chk("reset.pre.src_rdy", tx_p.src_rdy, 1'b0);
        chk("reset.pre.vld", tx_p.vld, 4'b0000);
        chk("reset.pre.data", tx_p.data, 32'h0);
        chk("reset.pre.dst_rdy", rx_p.dst_rdy, 1'b1);
        #2 reset_n = 1'b1;

        for (int k = 0; k < 7; k++) begin
            drive(vecs[k].data, vecs[k].vld, vecs[k].resync);
            step();
            chk($sformatf("vec%0d.ser.src_rdy", k), tx_s.src_rdy, vecs[k].fwd);
            chk($sformatf("vec%0d.pre.src_rdy", k), tx_p.src_rdy, vecs[k].fwd);
            if (vecs[k].fwd) begin
                chk($sformatf("vec%0d.ser.vld", k), tx_s.vld, vecs[k].exp_vld);
                chk($sformatf("vec%0d.pre.vld", k), tx_p.vld, vecs[k].exp_vld);
                chk($sformatf("vec%0d.ser.data", k), tx_s.data, vecs[k].data);
                chk($sformatf("vec%0d.pre.data", k), tx_p.data, vecs[k].data);
            end
        end
        drv_src = 1'b0; rx_resync = 1'b0;
        step();

        // Stall with a second word waiting, then release.
        drive(32'h00000031, 4'b0001, 1'b0);
        tx_rdy = 1'b0;
        step();
        chk("stall.load.src_rdy", tx_s.src_rdy, 1'b1);
        drive(32'h00000032, 4'b0001, 1'b0);
        repeat (5) begin
            step();
            chk("stall.ser.dst_rdy", rx_s.dst_rdy, 1'b0);
            chk("stall.pre.dst_rdy", rx_p.dst_rdy, 1'b0);
            chk("stall.ser.data", tx_s.data, 32'h00000031);
            chk("stall.pre.vld", tx_p.vld, 4'b0001);
        end
        tx_rdy = 1'b1;
        step();
        chk("release.ser.data", tx_s.data, 32'h00000032);
        chk("release.pre.data", tx_p.data, 32'h00000032);
        drv_src = 1'b0;
        step();
        chk("release.drain.src_rdy", tx_s.src_rdy, 1'b0);

        // Asynchronous reset with a word in the output register.
        drive(32'h00000040, 4'b0001, 1'b0);
        step();
        chk("inflight.src_rdy", tx_s.src_rdy, 1'b1);
        drv_src = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst.ser.src_rdy", tx_s.src_rdy, 1'b0);
        chk("async_rst.pre.src_rdy", tx_p.src_rdy, 1'b0);
        model_reset();
        #2 reset_n = 1'b1;
        drive(32'h00000000, 4'b0001, 1'b0);
        step();
        chk("post_rst.zero.ser.vld", tx_s.vld, 4'b0001);
        chk("post_rst.zero.pre.src_rdy", tx_p.src_rdy, 1'b1);
        drive(32'h000000AA, 4'b0001, 1'b0);
        step();
        chk("post_rst.aa.ser.vld", tx_s.vld, 4'b0001);
        chk("post_rst.aa.pre.data", tx_p.data, 32'h000000AA);

        // Random traffic with stalls; small alphabet so repeats are common.
        for (int n = 0; n < 10000; n++) begin
            drv_src = ($urandom_range(0, 9) < 8);
            drv_vld = 4'($urandom);
            for (int i = 0; i < ITEMS; i++) drv_data[i*W +: W] = 8'($urandom_range(0, 3));
            rx_resync = ($urandom_range(0, 19) == 0);
            tx_rdy = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
